// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the register-file writeback arbiter.
package regfile_pkg;

  localparam int unsigned REG_ADDR_W     = 5;
  localparam int unsigned REG_DATA_W     = 32;
  localparam int unsigned WB_QUEUE_DEPTH = 2;

  // One queued writeback: destination register and value
  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_entry_t;

  // Identity of the most recently granted requester
  typedef enum logic {
    GRANT_A = 1'b0,
    GRANT_B = 1'b1
  } grant_e;

endpackage

// File: rtl/wb_fifo.sv
// In-order writeback queue: per-slot valid bits, head outputs, and all-slot
// address/valid taps so the parent can build its pending-write mask.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH = WB_QUEUE_DEPTH,
  parameter int unsigned AW    = REG_ADDR_W,
  parameter int unsigned DW    = REG_DATA_W
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [AW-1:0]          push_addr_i,
  input  logic [DW-1:0]          push_data_i,
  input  logic                   pop_i,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [AW-1:0]          head_addr_o,
  output logic [DW-1:0]          head_data_o,
  output logic [DEPTH-1:0][AW-1:0] tap_addr_o,
  output logic [DEPTH-1:0]       tap_valid_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0][AW-1:0] addr_q;
  logic [DEPTH-1:0][DW-1:0] data_q;
  logic [DEPTH-1:0]         valid_q, valid_d;
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic                     full, empty;
  logic                     do_push, do_pop;

  // Occupancy comes straight from the slot valid bits
  assign full    = &valid_q;
  assign empty   = ~|valid_q;
  assign do_push = push_i && !full;
  assign do_pop  = pop_i && !empty;

  // Pointer and valid-bit next state; pointers wrap since DEPTH is a power of two
  always_comb begin
    valid_d  = valid_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PTR_W'(1);
    end
    if (do_push) begin
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + PTR_W'(1);
    end
  end

  // Control state register; reset flushes every slot
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Payload storage; contents are only meaningful where valid_q is set
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      addr_q[wr_ptr_q] <= push_addr_i;
      data_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign full_o      = full;
  assign empty_o     = empty;
  assign head_addr_o = addr_q[rd_ptr_q];
  assign head_data_o = data_q[rd_ptr_q];
  assign tap_addr_o  = addr_q;
  assign tap_valid_o = valid_q;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file write port between ALU writeback (A) and load
// writeback (B). Each requester feeds a wb_fifo; one entry is granted per
// cycle into a registered write stage, and Pending flags every register with
// a queued or staged write. Define ARB_FIXED_PRIORITY_EN to make A always win
// ties instead of round-robin.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = REG_DATA_W,
  parameter int unsigned ADDR_WIDTH = REG_ADDR_W,
  parameter int unsigned DEPTH      = WB_QUEUE_DEPTH
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       ValidA,
  output logic                       ReadyA,
  input  logic [ADDR_WIDTH-1:0]      AddrA,
  input  logic [DATA_WIDTH-1:0]      DataA,
  input  logic                       ValidB,
  output logic                       ReadyB,
  input  logic [ADDR_WIDTH-1:0]      AddrB,
  input  logic [DATA_WIDTH-1:0]      DataB,
  output logic                       RegWrite,
  output logic [ADDR_WIDTH-1:0]      WriteRegister,
  output logic [DATA_WIDTH-1:0]      WriteData,
  output logic [(2**ADDR_WIDTH)-1:0] Pending
);

  localparam int unsigned NUM_REGS = 2**ADDR_WIDTH;

  logic                            full_a, empty_a, full_b, empty_b;
  logic [ADDR_WIDTH-1:0]           head_addr_a, head_addr_b;
  logic [DATA_WIDTH-1:0]           head_data_a, head_data_b;
  logic [DEPTH-1:0][ADDR_WIDTH-1:0] tap_addr_a, tap_addr_b;
  logic [DEPTH-1:0]                tap_valid_a, tap_valid_b;
  logic                            gnt_a, gnt_b;

  logic                  reg_write_q, reg_write_d;
  logic [ADDR_WIDTH-1:0] write_reg_q, write_reg_d;
  logic [DATA_WIDTH-1:0] write_data_q, write_data_d;
  logic [NUM_REGS-1:0]   pending_c;

  // Ready is purely a function of registered occupancy
  assign ReadyA = !full_a;
  assign ReadyB = !full_b;

  wb_fifo #(.DEPTH(DEPTH), .AW(ADDR_WIDTH), .DW(DATA_WIDTH)) u_fifo_a (
    .clk_i       (Clk),
    .rst_i       (Reset),
    .push_i      (ValidA),
    .push_addr_i (AddrA),
    .push_data_i (DataA),
    .pop_i       (gnt_a),
    .full_o      (full_a),
    .empty_o     (empty_a),
    .head_addr_o (head_addr_a),
    .head_data_o (head_data_a),
    .tap_addr_o  (tap_addr_a),
    .tap_valid_o (tap_valid_a)
  );

  wb_fifo #(.DEPTH(DEPTH), .AW(ADDR_WIDTH), .DW(DATA_WIDTH)) u_fifo_b (
    .clk_i       (Clk),
    .rst_i       (Reset),
    .push_i      (ValidB),
    .push_addr_i (AddrB),
    .push_data_i (DataB),
    .pop_i       (gnt_b),
    .full_o      (full_b),
    .empty_o     (empty_b),
    .head_addr_o (head_addr_b),
    .head_data_o (head_data_b),
    .tap_addr_o  (tap_addr_b),
    .tap_valid_o (tap_valid_b)
  );

`ifdef ARB_FIXED_PRIORITY_EN
  // Fixed priority: B only when A has nothing queued
  always_comb begin
    gnt_a = !empty_a;
    gnt_b = empty_a && !empty_b;
  end
`else
  grant_e last_grant_q, last_grant_d;

  // Round-robin: on a tie, grant whoever did not win last time
  always_comb begin
    gnt_a = !empty_a && (empty_b || (last_grant_q == GRANT_B));
    gnt_b = !empty_b && !gnt_a;
  end

  // Remember the last winner; hold when nothing was granted
  always_comb begin
    last_grant_d = last_grant_q;
    if (gnt_a) begin
      last_grant_d = GRANT_A;
    end else if (gnt_b) begin
      last_grant_d = GRANT_B;
    end
  end

  // LastGrant register; reset favours A on the first tie
  always_ff @(posedge Clk) begin
    if (Reset) begin
      last_grant_q <= GRANT_B;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  // Write stage next state: load the granted head, suppress writes to r0
  always_comb begin
    reg_write_d  = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    if (gnt_a) begin
      reg_write_d  = (head_addr_a != '0);
      write_reg_d  = head_addr_a;
      write_data_d = head_data_a;
    end else if (gnt_b) begin
      reg_write_d  = (head_addr_b != '0);
      write_reg_d  = head_addr_b;
      write_data_d = head_data_b;
    end
  end

  // Registered register-file write port
  always_ff @(posedge Clk) begin
    if (Reset) begin
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
    end else begin
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
    end
  end

  // Pending mask: every valid queued entry plus the live staged write, never r0
  always_comb begin
    pending_c = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (tap_valid_a[i]) pending_c[tap_addr_a[i]] = 1'b1;
      if (tap_valid_b[i]) pending_c[tap_addr_b[i]] = 1'b1;
    end
    if (reg_write_q) pending_c[write_reg_q] = 1'b1;
    pending_c[0] = 1'b0;
  end

  assign RegWrite      = reg_write_q;
  assign WriteRegister = write_reg_q;
  assign WriteData     = write_data_q;
  assign Pending       = pending_c;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: transaction-level queue model with a
// register-file image, directed scenarios followed by random traffic.
`timescale 1ns/1ps
module tb_regfile_write_arbiter;
  import regfile_pkg::*;

  localparam int unsigned AW    = REG_ADDR_W;
  localparam int unsigned DW    = REG_DATA_W;
  localparam int unsigned DEPTH = WB_QUEUE_DEPTH;
  localparam int unsigned NREG  = 1 << AW;

  logic            Clk = 1'b0;
  logic            Reset, ValidA, ValidB, ReadyA, ReadyB, RegWrite;
  logic [AW-1:0]   AddrA, AddrB, WriteRegister;
  logic [DW-1:0]   DataA, DataB, WriteData;
  logic [NREG-1:0] Pending;

  regfile_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .Clk(Clk), .Reset(Reset),
    .ValidA(ValidA), .ReadyA(ReadyA), .AddrA(AddrA), .DataA(DataA),
    .ValidB(ValidB), .ReadyB(ReadyB), .AddrB(AddrB), .DataB(DataB),
    .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
    .Pending(Pending)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  wb_entry_t     mq_a[$], mq_b[$];
  bit            m_last_b = 1'b1;
  bit            m_rw = 1'b0;
  logic [AW-1:0] m_wr = '0;
  logic [DW-1:0] m_wd = '0;
  logic [DW-1:0] m_rf [NREG];

  // Register file image driven by the DUT's write port
  logic [DW-1:0] d_rf [NREG];
  logic          s_rw = 1'b0;
  logic [AW-1:0] s_wr = '0;
  logic [DW-1:0] s_wd = '0;
  int            cyc = 0;
  int            wlog_reg[$];
  int            wlog_cyc[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NREG-1:0] model_pending();
    logic [NREG-1:0] p;
    p = '0;
    foreach (mq_a[i]) p[mq_a[i].addr] = 1'b1;
    foreach (mq_b[i]) p[mq_b[i].addr] = 1'b1;
    if (m_rw) p[m_wr] = 1'b1;
    p[0] = 1'b0;
    return p;
  endfunction

  // Advance the model across one clock edge using the inputs presented at it
  task automatic model_edge();
    int sa = mq_a.size();
    int sb = mq_b.size();
    bit ga, gb;
    wb_entry_t e;
    if (m_rw) m_rf[m_wr] = m_wd;
    if (Reset) begin
      mq_a.delete(); mq_b.delete();
      m_last_b = 1'b1; m_rw = 1'b0; m_wr = '0; m_wd = '0;
      return;
    end
`ifdef ARB_FIXED_PRIORITY_EN
    ga = (sa != 0);
`else
    ga = (sa != 0) && ((sb == 0) || m_last_b);
`endif
    gb = !ga && (sb != 0);
    if (ga || gb) begin
      e = ga ? mq_a.pop_front() : mq_b.pop_front();
      m_rw = (e.addr != '0);
      m_wr = e.addr;
      m_wd = e.data;
      m_last_b = gb;
    end else begin
      m_rw = 1'b0;
    end
    if (ValidA && sa < int'(DEPTH)) mq_a.push_back('{addr: AddrA, data: DataA});
    if (ValidB && sb < int'(DEPTH)) mq_b.push_back('{addr: AddrB, data: DataB});
  endtask

  // One clock: commit observed write, step model, then check all outputs
  task automatic cycle();
    @(posedge Clk);
    if (s_rw) begin
      d_rf[s_wr] = s_wd;
      wlog_reg.push_back(int'(s_wr));
      wlog_cyc.push_back(cyc);
    end
    model_edge();
    cyc++;
    #1;
    s_rw = RegWrite; s_wr = WriteRegister; s_wd = WriteData;
    chk("ReadyA", 64'(ReadyA), 64'(mq_a.size() < int'(DEPTH)));
    chk("ReadyB", 64'(ReadyB), 64'(mq_b.size() < int'(DEPTH)));
    chk("RegWrite", 64'(RegWrite), 64'(m_rw));
    chk("WriteRegister", 64'(WriteRegister), 64'(m_wr));
    chk("WriteData", 64'(WriteData), 64'(m_wd));
    chk("Pending", 64'(Pending), 64'(model_pending()));
  endtask

  // Push na writes on A and nb on B with full handshake, for ncyc cycles
  task automatic run_streams(input int na, input int a_base, input int nb, input int b_base,
                             input int ncyc, output int acc_a, output int acc_b, output logic rb2);
    logic ra, rb;
    acc_a = 0; acc_b = 0; rb2 = 1'b1;
    for (int k = 0; k < ncyc; k++) begin
      ValidA = (acc_a < na); AddrA = AW'(a_base + acc_a); DataA = DW'(32'hA000_0000 + acc_a);
      ValidB = (acc_b < nb); AddrB = AW'(b_base + acc_b); DataB = DW'(32'hB000_0000 + acc_b);
      ra = ReadyA; rb = ReadyB;
      cycle();
      if (ValidA && ra) acc_a++;
      if (ValidB && rb) begin
        acc_b++;
        if (acc_b == 2) rb2 = ReadyB;
      end
    end
    ValidA = 1'b0; ValidB = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int   base, acc_a, acc_b, nlog;
    logic rb2, ra;
    int   exp_order[6];
`ifdef ARB_FIXED_PRIORITY_EN
    exp_order = '{1, 2, 3, 11, 12, 13};
`else
    exp_order = '{1, 11, 2, 12, 3, 13};
`endif
    for (int r = 0; r < int'(NREG); r++) begin
      m_rf[r] = '0; d_rf[r] = '0;
    end

    // Reset held two cycles with both requesters valid
    Reset = 1'b1; ValidA = 1'b1; ValidB = 1'b1;
    AddrA = AW'(7); AddrB = AW'(9); DataA = DW'(32'h1111); DataB = DW'(32'h2222);
    cycle();
    cycle();
    chk("rst_regwrite", 64'(RegWrite), 64'(0));
    chk("rst_pending", 64'(Pending), 64'(0));
    Reset = 1'b0; ValidA = 1'b0; ValidB = 1'b0;
    cycle();
    chk("rst_no_accept", 64'(Pending), 64'(0));
    chk("rst_no_write", 64'(RegWrite), 64'(0));

    // Single write to r5
    ValidA = 1'b1; AddrA = AW'(5); DataA = DW'(32'hDEADBEEF);
    cycle();
    ValidA = 1'b0;
    chk("single_pend_set", 64'(Pending[5]), 64'(1));
    chk("single_rw_not_yet", 64'(RegWrite), 64'(0));
    cycle();
    chk("single_rw", 64'(RegWrite), 64'(1));
    chk("single_wr", 64'(WriteRegister), 64'(5));
    chk("single_wd", 64'(WriteData), 64'(32'hDEADBEEF));
    chk("single_pend_staged", 64'(Pending[5]), 64'(1));
    cycle();
    chk("single_rw_off", 64'(RegWrite), 64'(0));
    chk("single_pend_clr", 64'(Pending[5]), 64'(0));

    // Contention: A r1..r3 against B r11..r13
    Reset = 1'b1; cycle(); Reset = 1'b0;
    base = wlog_reg.size();
    run_streams(3, 1, 3, 11, 20, acc_a, acc_b, rb2);
    chk("cont_nwrites", 64'(wlog_reg.size() - base), 64'(6));
    if (wlog_reg.size() >= base + 6) begin
      for (int j = 0; j < 6; j++) chk("cont_order", 64'(wlog_reg[base + j]), 64'(exp_order[j]));
      for (int j = 1; j < 6; j++) chk("cont_no_idle", 64'(wlog_cyc[base + j] - wlog_cyc[base + j - 1]), 64'(1));
    end

    // Backpressure on B while A keeps its queue busy
    Reset = 1'b1; cycle(); Reset = 1'b0;
    run_streams(6, 20, 3, 11, 25, acc_a, acc_b, rb2);
    chk("bp_readyB_low_after_2", 64'(rb2), 64'(0));
    chk("bp_b_all_accepted", 64'(acc_b), 64'(3));
    chk("bp_a_all_accepted", 64'(acc_a), 64'(6));

    // Write to r0 is accepted but never lands
    ValidA = 1'b1; AddrA = '0; DataA = DW'(32'h1234);
    ra = ReadyA;
    cycle();
    ValidA = 1'b0;
    chk("r0_accepted", 64'(ra), 64'(1));
    chk("r0_pending_q", 64'(Pending), 64'(0));
    cycle();
    chk("r0_regwrite", 64'(RegWrite), 64'(0));
    chk("r0_pending_s", 64'(Pending), 64'(0));
    cycle();
    chk("r0_reads_zero", 64'(d_rf[0]), 64'(0));

    // Random traffic with held payloads under backpressure
    ValidA = 1'b0; ValidB = 1'b0;
    for (int k = 0; k < 300; k++) begin
      logic rra, rrb;
      if (!ValidA) begin
        ValidA = ($urandom_range(0, 3) != 0);
        AddrA  = AW'($urandom_range(0, NREG - 1));
        DataA  = DW'($urandom);
      end
      if (!ValidB) begin
        ValidB = ($urandom_range(0, 2) != 0);
        AddrB  = AW'($urandom_range(0, NREG - 1));
        DataB  = DW'($urandom);
      end
      rra = ReadyA; rrb = ReadyB;
      cycle();
      if (ValidA && rra) ValidA = 1'b0;
      if (ValidB && rrb) ValidB = 1'b0;
    end
    ValidA = 1'b0; ValidB = 1'b0;
    repeat (6) cycle();

    // Reset with entries queued and one staged
    ValidA = 1'b1; AddrA = AW'(3); DataA = DW'(32'h33); ValidB = 1'b1; AddrB = AW'(4); DataB = DW'(32'h44);
    cycle();
    AddrA = AW'(6); DataA = DW'(32'h66); AddrB = AW'(7); DataB = DW'(32'h77);
    cycle();
    ValidA = 1'b0; ValidB = 1'b0;
    chk("mf_staged", 64'(RegWrite), 64'(1));
    Reset = 1'b1;
    cycle();
    Reset = 1'b0;
    chk("mf_regwrite", 64'(RegWrite), 64'(0));
    chk("mf_pending", 64'(Pending), 64'(0));
    chk("mf_readyA", 64'(ReadyA), 64'(1));
    chk("mf_readyB", 64'(ReadyB), 64'(1));
    nlog = wlog_reg.size();
    repeat (5) cycle();
    chk("mf_no_later_write", 64'(wlog_reg.size()), 64'(nlog));

    // Final register file image
    for (int r = 0; r < int'(NREG); r++) chk("regfile", 64'(d_rf[r]), 64'(m_rf[r]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
